// File: rtl/gpio_seq.sv
// gpio_seq: memory-mapped GPIO output sequencer.
// Software pushes (value, duration) entries into a FIFO; the sequencer plays
// them on 8 output pins, each held (duration+1)*(PRESCALE+1) clock cycles,
// and raises a done interrupt when the FIFO drains.
//
// Register window (word offsets from ADDR):
//   +0  CTRL      [0] enable, [1] flush (self-clearing), [2] loop, [3] irq_en
//   +4  STATUS    [0] busy, [1] empty, [2] full, [3] overflow (W1C),
//                 [4] done (W1C), [15:8] count
//   +8  PUSH      [7:0] value, [23:8] duration (write only)
//   +12 PRESCALE  [15:0]
//   +16 DIRECT    [7:0] pin value, applied only while idle
//
// Optional feature: define GPIO_SEQ_LOOP_EN to enable loop mode (CTRL[2]),
// in which every popped entry is re-pushed at the FIFO tail. Without the
// macro CTRL[2] is ignored and reads 0.

module gpio_seq #(
    parameter logic [31:0] ADDR  = 32'hffff_ffff,
    parameter int          DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        seq_ready,
    output logic        seq_sel,
    output logic [31:0] seq_rdata,
    output logic [7:0]  gpio_pin_out,
    output logic        seq_irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic hit_ctrl, hit_stat, hit_push, hit_presc, hit_direct;
    logic bus_wr;
    logic ctrl_wr, stat_wr, push_wr, presc_wr, direct_wr;
    logic flush_req, push_req;

    assign hit_ctrl   = (mem_addr == ADDR);
    assign hit_stat   = (mem_addr == ADDR + 32'd4);
    assign hit_push   = (mem_addr == ADDR + 32'd8);
    assign hit_presc  = (mem_addr == ADDR + 32'd12);
    assign hit_direct = (mem_addr == ADDR + 32'd16);

    assign seq_ready = 1'b1;
    assign seq_sel   = mem_valid & (hit_ctrl | hit_stat | hit_push | hit_presc | hit_direct);
    assign bus_wr    = seq_sel & (|mem_wstrb);

    assign ctrl_wr   = bus_wr & hit_ctrl;
    assign stat_wr   = bus_wr & hit_stat;
    assign push_wr   = bus_wr & hit_push;
    assign presc_wr  = bus_wr & hit_presc;
    assign direct_wr = bus_wr & hit_direct;

    // A flush in the same cycle as a push discards the push silently.
    assign flush_req = ctrl_wr & mem_wdata[1];
    assign push_req  = push_wr & ~flush_req;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic        enable_q, irq_en_q, loop_q;
    logic [15:0] prescale_q;
    logic        overflow_q, done_q;
    logic        overflow_set, done_set;

`ifdef GPIO_SEQ_LOOP_EN
    // Loop-mode bit, written together with the rest of CTRL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            loop_q <= 1'b0;
        else if (ctrl_wr)
            loop_q <= mem_wdata[2];
    end
`else
    assign loop_q = 1'b0;
`endif

    // CTRL, PRESCALE and the sticky W1C status bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= mem_wdata[0];
                irq_en_q <= mem_wdata[3];
            end
            if (presc_wr)
                prescale_q <= mem_wdata[15:0];
            // A hardware set in the same cycle as a W1C leaves the bit set.
            overflow_q <= (overflow_q & ~(stat_wr & mem_wdata[3])) | overflow_set;
            done_q     <= (done_q     & ~(stat_wr & mem_wdata[4])) | done_set;
        end
    end

    assign seq_irq = done_q & irq_en_q;

    // ------------------------------------------------------------------
    // FIFO of {duration, value} entries
    // ------------------------------------------------------------------
    logic [23:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          empty, full;
    logic [23:0]   head;
    logic          pop, repush, host_ok;
    logic [1:0]    n_in;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign head   = fifo_mem[rptr_q];
    assign repush = pop & loop_q;

    // With a recirculating pop the freed slot is reused by the repush, so a
    // host push then needs a genuinely free slot; otherwise a simultaneous
    // pop makes room even when full.
    assign host_ok      = push_req & (repush ? ~full : (~full | pop));
    assign overflow_set = push_req & ~host_ok;
    assign n_in         = {1'b0, repush} + {1'b0, host_ok};

    // Entry storage: the repushed head goes first, the host entry behind it.
    // NOTE: storage is not reset; occupancy is tracked by count/pointers,
    // so stale contents are never observed and a reset would only cost area.
    always_ff @(posedge clk) begin
        if (repush) begin
            fifo_mem[wptr_q] <= head;
            if (host_ok)
                fifo_mem[AW'(wptr_q + 1'b1)] <= mem_wdata[23:0];
        end else if (host_ok) begin
            fifo_mem[wptr_q] <= mem_wdata[23:0];
        end
    end

    // Pointer and occupancy tracking; flush wins over everything.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_req) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(n_in);
            rptr_q  <= rptr_q + AW'(pop);
            count_q <= count_q + CW'(n_in) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] dur_cnt_q, presc_cnt_q;
    logic [7:0]  pins_q;
    logic        tick, dur_zero;

    assign tick     = (presc_cnt_q == prescale_q);
    assign dur_zero = (dur_cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, pop and done decisions.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_req && enable_q && !empty) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush_req || !enable_q) begin
                    state_d = IDLE;
                end else if (tick && dur_zero) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        done_set = ~loop_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin, duration and prescale counters; a pop reloads all three.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pins_q      <= '0;
            dur_cnt_q   <= '0;
            presc_cnt_q <= '0;
        end else if (pop) begin
            pins_q      <= head[7:0];
            dur_cnt_q   <= head[23:8];
            presc_cnt_q <= '0;
        end else begin
            if (direct_wr && state_q == IDLE)
                pins_q <= mem_wdata[7:0];
            if (state_q == HOLD && tick && !dur_zero)
                dur_cnt_q <= dur_cnt_q - 16'd1;
            if (state_q == HOLD)
                presc_cnt_q <= tick ? 16'd0 : presc_cnt_q + 16'd1;
            else
                presc_cnt_q <= '0;
        end
    end

    assign gpio_pin_out = pins_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational read data; zero whenever the access is not ours.
    always_comb begin
        seq_rdata = '0;
        if (mem_valid) begin
            if (hit_ctrl)
                seq_rdata = {28'd0, irq_en_q, loop_q, 1'b0, enable_q};
            else if (hit_stat)
                seq_rdata = {16'd0, 8'(count_q), 3'd0, done_q, overflow_q,
                             full, empty, (state_q == HOLD)};
            else if (hit_presc)
                seq_rdata = {16'd0, prescale_q};
            else if (hit_direct)
                seq_rdata = {24'd0, pins_q};
        end
    end

    // Upper write-data bits carry no register field.
    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[31:24];

endmodule
